// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control, prioritised next-PC selection,
// misaligned-target trapping, exception PC and retired-instruction counter.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_offset,
  input  logic             jump_reg,
  input  logic [XLEN-1:0]  jump_target,
  input  logic             trap,
  input  logic             trap_ret,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             pc_valid,
  output logic             halted,
  output logic             misaligned,
  output logic [XLEN-1:0]  epc,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t           state, state_nxt;
  logic [XLEN-1:0]  pc_nxt, epc_nxt, redir_tgt;
  logic [CNT_W-1:0] instret_nxt;
  logic             mis_nxt;

  assign pc_plus4 = pc + XLEN'(4);
  assign pc_valid = (state == RUN);
  assign halted   = (state == HALT);

  // JALR drops bit 0; only bit 1 of the resulting target can misalign it.
  assign redir_tgt = jump_reg ? {jump_target[XLEN-1:1], 1'b0} : pc + branch_offset;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    epc_nxt     = epc;
    instret_nxt = instret;
    mis_nxt     = 1'b0;
    if (!stall) begin
      case (state)
        BOOT: state_nxt = RUN;
        RUN: begin
          instret_nxt = instret + CNT_W'(1);
          if (trap) begin
            epc_nxt = pc;
            pc_nxt  = TRAP_VECTOR;
          end else if (trap_ret) begin
            pc_nxt = epc;
          end else if (jump_reg || branch_taken) begin
            if (redir_tgt[1]) begin
              epc_nxt = pc;
              pc_nxt  = TRAP_VECTOR;
              mis_nxt = 1'b1;
            end else begin
              pc_nxt = redir_tgt;
            end
          end else if (halt_req) begin
            state_nxt = HALT;
          end else begin
            pc_nxt = pc_plus4;
          end
        end
        HALT: if (resume) begin
          state_nxt = RUN;
          pc_nxt    = pc_plus4;
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      pc         <= RESET_VECTOR;
      epc        <= '0;
      instret    <= '0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      epc        <= epc_nxt;
      instret    <= instret_nxt;
      misaligned <= mis_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall, halt_req, resume, branch_taken, jump_reg, trap, trap_ret;
  logic [31:0] branch_offset, jump_target;
  logic [31:0] pc, pc_plus4, epc, instret;
  logic        pc_valid, halted, misaligned;

  logic        b16;
  logic [15:0] off16, pc16, pc16p4, epc16, zero16;
  logic [7:0]  instret16;
  logic        v16, h16, m16;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req), .resume(resume),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jump_reg(jump_reg),
    .jump_target(jump_target), .trap(trap), .trap_ret(trap_ret), .pc(pc),
    .pc_plus4(pc_plus4), .pc_valid(pc_valid), .halted(halted), .misaligned(misaligned),
    .epc(epc), .instret(instret)
  );

  assign zero16 = '0;

  pc_sequencer #(.XLEN(16), .CNT_W(8)) dut16 (
    .clk(clk), .reset(reset), .stall(1'b0), .halt_req(1'b0), .resume(1'b0),
    .branch_taken(b16), .branch_offset(off16), .jump_reg(1'b0), .jump_target(zero16),
    .trap(1'b0), .trap_ret(1'b0), .pc(pc16), .pc_plus4(pc16p4), .pc_valid(v16),
    .halted(h16), .misaligned(m16), .epc(epc16), .instret(instret16)
  );

  // Behavioural model: 0 = boot, 1 = running, 2 = halted.
  int          m_st;
  logic [31:0] m_pc, m_epc, m_cnt;
  logic        m_mis;

  int          n_st;
  logic [31:0] n_pc, n_epc, n_cnt, n_tgt;
  logic        n_mis;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st <= 0; m_pc <= 32'h0; m_epc <= 32'h0; m_cnt <= 32'h0; m_mis <= 1'b0;
    end else begin
      n_st = m_st; n_pc = m_pc; n_epc = m_epc; n_cnt = m_cnt; n_mis = 1'b0;
      if (!stall) begin
        if (m_st == 0) n_st = 1;
        else if (m_st == 2) begin
          if (resume) begin n_st = 1; n_pc = m_pc + 32'd4; end
        end else begin
          n_cnt = m_cnt + 32'd1;
          n_tgt = jump_reg ? (jump_target & ~32'd1) : m_pc + branch_offset;
          if (trap) begin n_epc = m_pc; n_pc = 32'h100; end
          else if (trap_ret) n_pc = m_epc;
          else if ((jump_reg || branch_taken) && (n_tgt % 4 >= 2)) begin
            n_epc = m_pc; n_pc = 32'h100; n_mis = 1'b1;
          end
          else if (jump_reg || branch_taken) n_pc = n_tgt;
          else if (halt_req) n_st = 2;
          else n_pc = m_pc + 32'd4;
        end
      end
      m_st <= n_st; m_pc <= n_pc; m_epc <= n_epc; m_cnt <= n_cnt; m_mis <= n_mis;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("pc",         64'(pc),         64'(m_pc));
      chk("pc_plus4",   64'(pc_plus4),   64'(m_pc + 32'd4));
      chk("pc_valid",   64'(pc_valid),   64'(m_st == 1));
      chk("halted",     64'(halted),     64'(m_st == 2));
      chk("misaligned", 64'(misaligned), 64'(m_mis));
      chk("epc",        64'(epc),        64'(m_epc));
      chk("instret",    64'(instret),    64'(m_cnt));
    end
  end

  task automatic clr();
    stall = 0; halt_req = 0; resume = 0; branch_taken = 0; jump_reg = 0;
    trap = 0; trap_ret = 0; branch_offset = '0; jump_target = '0;
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] cnt_save;

  initial begin
    clr(); b16 = 0; off16 = '0;
    cyc(2);
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_valid", 64'(pc_valid), 64'h0);
    chk("rst_instret", 64'(instret), 64'h0);
    chk("rst_epc", 64'(epc), 64'h0);
    chk("rst_mis", 64'(misaligned), 64'h0);
    chk("rst_halted", 64'(halted), 64'h0);
    reset = 0; cmp_en = 1;
    cyc(); chk("boot_pc", 64'(pc), 64'h0); chk("boot_valid", 64'(pc_valid), 64'h1);
    cyc(); chk("seq_pc4", 64'(pc), 64'h4);
    cyc(); chk("seq_pc8", 64'(pc), 64'h8); chk("seq_instret", 64'(instret), 64'd2);
    cyc(2); chk("at_10", 64'(pc), 64'h10);
    branch_taken = 1; branch_offset = -32'sd8;
    cyc(); chk("br_back", 64'(pc), 64'h8);
    clr(); cyc(2);
    branch_taken = 1; branch_offset = 32'd6;
    cyc(); chk("br_mis_pc", 64'(pc), 64'h100); chk("br_mis_epc", 64'(epc), 64'h10);
    chk("br_mis_pulse", 64'(misaligned), 64'h1); chk("model_pc", 64'(m_pc), 64'h100);
    clr(); cyc(); chk("mis_clear", 64'(misaligned), 64'h0);
    jump_reg = 1; jump_target = 32'h20; cyc();
    jump_target = 32'h41; cyc(); chk("jalr_pc", 64'(pc), 64'h40);
    clr(); trap = 1; cyc(); chk("trap_pc", 64'(pc), 64'h100); chk("trap_epc", 64'(epc), 64'h40);
    clr(); trap_ret = 1; cyc(); chk("mret_pc", 64'(pc), 64'h40);
    clr(); jump_reg = 1; jump_target = 32'h30; cyc();
    clr(); trap = 1; branch_taken = 1; branch_offset = 32'h8; halt_req = 1; cyc();
    chk("prio_pc", 64'(pc), 64'h100); chk("prio_epc", 64'(epc), 64'h30);
    chk("prio_run", 64'(halted), 64'h0);
    clr(); jump_reg = 1; jump_target = 32'h50; cyc();
    clr(); halt_req = 1; cyc();
    chk("halt_flag", 64'(halted), 64'h1); chk("halt_valid", 64'(pc_valid), 64'h0);
    cnt_save = instret;
    clr(); trap = 1; branch_taken = 1; branch_offset = 32'h40; jump_reg = 1; jump_target = 32'h80;
    for (int i = 0; i < 5; i++) begin
      cyc(); chk("halt_pc", 64'(pc), 64'h50); chk("halt_cnt", 64'(instret), 64'(cnt_save));
    end
    clr(); resume = 1; cyc();
    chk("resume_pc", 64'(pc), 64'h54); chk("resume_valid", 64'(pc_valid), 64'h1);
    cnt_save = instret;
    clr(); stall = 1; branch_taken = 1; branch_offset = 32'h40;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("stall_pc", 64'(pc), 64'h54); chk("stall_cnt", 64'(instret), 64'(cnt_save));
    end
    clr(); branch_taken = 1; branch_offset = 32'h20;
    #2 reset = 1;
    #1 chk("midrst_pc", 64'(pc), 64'h0); chk("midrst_cnt", 64'(instret), 64'h0);
    chk("midrst_valid", 64'(pc_valid), 64'h0);
    cyc(); clr(); reset = 0;

    for (int i = 0; i < 600; i++) begin
      stall         = ($urandom_range(0, 7) == 0);
      trap          = ($urandom_range(0, 19) == 0);
      trap_ret      = ($urandom_range(0, 19) == 0);
      jump_reg      = ($urandom_range(0, 7) == 0);
      branch_taken  = ($urandom_range(0, 5) == 0);
      halt_req      = ($urandom_range(0, 24) == 0);
      resume        = ($urandom_range(0, 3) == 0);
      branch_offset = 32'($urandom_range(0, 127)) - 32'd64;
      jump_target   = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) begin
        reset = 1; cyc(); reset = 0;
      end
      cyc();
    end

    clr(); reset = 1; cyc(); reset = 0;
    cyc();
    b16 = 1; off16 = 16'hFFFC; cyc();
    chk("x16_pc", 64'(pc16), 64'hFFFC); chk("x16_plus4", 64'(pc16p4), 64'h0);
    b16 = 0; cyc();
    chk("x16_wrap", 64'(pc16), 64'h0);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle RISC-V core; the next generation of the core's PC register. It owns the fetch address and picks the next PC from sequential, PC-relative branch, register-indirect jump, trap and trap-return sources. It adds a boot/run/halt state machine, misaligned-target trapping, an exception PC register and a retired-instruction counter. Sits between the decode/ALU stage (control inputs) and instruction memory (`pc` output).

## Interface
- `XLEN`, 32: address/data width in bits (16..64).
- `RESET_VECTOR`, 0: first fetch address after reset.
- `TRAP_VECTOR`, 32'h0000_0100: target loaded on a trap or misaligned target.
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk`  in  1  clock, rising-edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  freeze all state for this cycle.
- `halt_req`  in  1  current instruction is the finish/halt instruction.
- `resume`  in  1  leave HALT.
- `branch_taken`  in  1  conditional branch or JAL taken.
- `branch_offset`  in  XLEN  signed offset, relative to `pc`.
- `jump_reg`  in  1  JALR.
- `jump_target`  in  XLEN  rs1+imm from ALU.
- `trap`  in  1  synchronous exception from the current instruction.
- `trap_ret`  in  1  MRET-style return to `epc`.
- `pc`  out  XLEN  current fetch address.
- `pc_plus4`  out  XLEN  `pc`+4, combinational (link value).
- `pc_valid`  out  1  `pc` holds a real instruction to execute.
- `halted`  out  1  state is HALT.
- `misaligned`  out  1  one-cycle pulse: last redirect target was misaligned.
- `epc`  out  XLEN  PC of the most recent trapping instruction.
- `instret`  out  CNT_W  instructions retired.

## Operation
- States: BOOT, RUN, HALT.
- Reset (async): state BOOT, `pc`=RESET_VECTOR, `pc_valid`=0, `halted`=0, `misaligned`=0, `epc`=0, `instret`=0.
- BOOT: one cycle; next edge -> RUN, `pc` unchanged (first instruction is fetched at RESET_VECTOR; there is no -4 preload).
- RUN, `pc_valid`=1. On each edge with `stall`=0, next PC by strict priority:
  1. `trap`: `epc`<=`pc`, `pc`<=TRAP_VECTOR.
  2. `trap_ret`: `pc`<=`epc`.
  3. `jump_reg`: target = `jump_target` with bit 0 cleared.
  4. `branch_taken`: target = `pc`+`branch_offset`.
  5. `halt_req`: `pc` unchanged; state -> HALT.
  6. Otherwise `pc`<=`pc`+4.
- Targets from 3 or 4 with bit 1 set: do not load; `epc`<=`pc`, `pc`<=TRAP_VECTOR, `misaligned`=1 for the following cycle.
- `instret` increments on every RUN edge with `stall`=0, including the halting instruction and trapping instructions. It does not increment for the BOOT cycle or in HALT.
- `stall`=1: `pc`, state, `epc` and `instret` hold; all other inputs are ignored; `misaligned` clears.
- HALT: `pc_valid`=0, `halted`=1. All redirect inputs are ignored. `resume` -> RUN with `pc`<=`pc`+4.
- Arithmetic is modulo 2^XLEN; `pc`+4 and `pc`+offset wrap silently with no flag. `instret` wraps to 0.

## Timing
- All state updates on the rising `clk` edge; `reset` acts immediately and has priority over everything.
- Redirect latency: one cycle. Control asserted in cycle N gives the new `pc` in cycle N+1.
- `pc_plus4` is combinational from `pc`, with zero latency.
- `halted` and `pc_valid` change on the edge that enters or leaves HALT.
- Reset asserted mid-operation returns to BOOT at once. The in-flight redirect is discarded and `instret` clears.
- Simultaneous controls are resolved only by the priority list above; lower-priority inputs have no side effect.

## Test plan
- Reset, then 3 free-running cycles, RESET_VECTOR=0 -> `pc` sequence 0,0(BOOT->RUN),4,8; `instret`=2; `pc_valid` 0 then 1.
- At `pc`=0x10, `branch_taken`, offset=-8 -> `pc`=0x08. Offset=+6 -> `pc`=0x100, `epc`=0x10, `misaligned` pulse.
- At `pc`=0x20, `jump_reg`, target 0x41 -> `pc`=0x40. Then `trap` -> `pc`=0x100, `epc`=0x40. Then `trap_ret` -> `pc`=0x40.
- `trap`+`branch_taken`+`halt_req` in one cycle at `pc`=0x30 -> `pc`=0x100, state RUN, `epc`=0x30.
- `halt_req` at `pc`=0x50 -> `halted`=1, `pc` holds 0x50 for 5 cycles, `instret` frozen. `resume` -> `pc`=0x54, `pc_valid`=1.
- `stall` for 3 cycles with `branch_taken` set -> `pc` and `instret` unchanged. XLEN=16 with `pc`=0xFFFC sequential -> `pc`=0x0000. Reset mid-branch -> `pc`=RESET_VECTOR at once.
